// File: rtl/rv32i_mmio_responder_if.sv
// Shared memory port of the multicycle RV32I core plus the byte TX drain port.
//   mem_addr    : byte address from the core; bits [1:0] are ignored
//   mem_wr_data : write data from the core
//   mem_wr_ena  : write strobe, commits at the rising edge where it is high
//   mem_rd_data : combinational read data for mem_addr
//   tx_data     : FIFO head byte, 0 when empty
//   tx_valid    : FIFO non-empty
//   tx_ready    : consumer accepts the head byte this cycle
// Modport master belongs to the core/consumer side, slave to the responder.
interface rv32i_mmio_responder_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ena;
  logic [31:0] mem_rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output mem_addr,
    output mem_wr_data,
    output mem_wr_ena,
    input  mem_rd_data,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_wr_data,
    input  mem_wr_ena,
    output mem_rd_data,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );
endinterface

// File: rtl/rv32i_mmio_responder.sv
// Memory-side responder for the RV32I core's single memory port. Decodes
// mem_addr[31] into a word RAM (0) or an MMIO bank (1) at offset mem_addr[4:2]:
//   0 GPIO_OUT (RW 16b), 1 GPIO_IN (RO, 2-flop sync), 2 CYCLE (RO),
//   3 TIMER_CMP (RW), 4 STATUS (W1C sticky bits + FIFO state), 5 TX_DATA (WO push),
//   6/7 reserved (read 0).
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : memory port and TX drain (slave modport)
//   gpio_in  : asynchronous board inputs
//   gpio_out : GPIO output latch
//   irq      : sticky timer_hit flag
module rv32i_mmio_responder #(
  parameter int unsigned RAM_WORDS = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  rv32i_mmio_responder_if.slave         bus,
  input  logic [15:0]                   gpio_in,
  output logic [15:0]                   gpio_out,
  output logic                          irq
);

  localparam int unsigned AddrW = $clog2(RAM_WORDS);

  localparam logic [2:0] OffGpioOut  = 3'd0;
  localparam logic [2:0] OffGpioIn   = 3'd1;
  localparam logic [2:0] OffCycle    = 3'd2;
  localparam logic [2:0] OffTimerCmp = 3'd3;
  localparam logic [2:0] OffStatus   = 3'd4;
  localparam logic [2:0] OffTxData   = 3'd5;

  // Address decode
  logic             is_mmio;
  logic [2:0]       mmio_off;
  logic [AddrW-1:0] ram_idx;
  logic             ram_we;
  logic             mmio_we;
  logic             unused_addr;

  assign is_mmio     = bus.mem_addr[31];
  assign mmio_off    = bus.mem_addr[4:2];
  assign ram_idx     = bus.mem_addr[AddrW+1:2];
  assign ram_we      = bus.mem_wr_ena && !is_mmio;
  assign mmio_we     = bus.mem_wr_ena && is_mmio;
  assign unused_addr = ^bus.mem_addr;

  // RAM: asynchronous read, synchronous full-word write, not reset
  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= bus.mem_wr_data;
    end
  end

  // Register bank state
  logic [15:0] gpio_out_q, gpio_out_d;
  logic [15:0] sync1_q, sync2_q;
  logic [31:0] cycle_q;
  logic [31:0] cmp_q, cmp_d;
  logic        hit_q, hit_d;
  logic        ovf_q, ovf_d;

  // TX FIFO state
  logic [7:0] fifo_q [4];
  logic [1:0] rptr_q, rptr_d;
  logic [1:0] wptr_q, wptr_d;
  logic [2:0] count_q, count_d;

  logic tx_full;
  logic tx_empty;
  logic pop;
  logic push_req;
  logic push;
  logic status_we;

  assign tx_full   = (count_q == 3'd4);
  assign tx_empty  = (count_q == 3'd0);
  assign pop       = !tx_empty && bus.tx_ready;
  assign push_req  = mmio_we && (mmio_off == OffTxData);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept
  assign push      = push_req && (!tx_full || pop);
  assign status_we = mmio_we && (mmio_off == OffStatus);

  always_comb begin
    gpio_out_d = gpio_out_q;
    cmp_d      = cmp_q;
    hit_d      = hit_q;
    ovf_d      = ovf_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    count_d    = count_q;

    if (mmio_we && (mmio_off == OffGpioOut)) begin
      gpio_out_d = bus.mem_wr_data[15:0];
    end
    if (mmio_we && (mmio_off == OffTimerCmp)) begin
      cmp_d = bus.mem_wr_data;
    end

    // W1C first so that a same-cycle set overrides it
    if (status_we && bus.mem_wr_data[0]) begin
      hit_d = 1'b0;
    end
    if (cycle_q == cmp_q) begin
      hit_d = 1'b1;
    end
    if (status_we && bus.mem_wr_data[1]) begin
      ovf_d = 1'b0;
    end
    if (push_req && !push) begin
      ovf_d = 1'b1;
    end

    if (pop) begin
      rptr_d = rptr_q + 2'd1;
    end
    if (push) begin
      wptr_d = wptr_q + 2'd1;
    end
    count_d = count_q + {2'b00, push} - {2'b00, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      cycle_q    <= '0;
      cmp_q      <= 32'hFFFF_FFFF;
      hit_q      <= 1'b0;
      ovf_q      <= 1'b0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
      cycle_q    <= cycle_q + 32'd1;
      cmp_q      <= cmp_d;
      hit_q      <= hit_d;
      ovf_q      <= ovf_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage needs no reset; tx_data is masked while empty
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q] <= bus.mem_wr_data[7:0];
    end
  end

  // Read mux
  logic [31:0] mmio_rd;

  always_comb begin
    mmio_rd = '0;
    case (mmio_off)
      OffGpioOut:  mmio_rd = {16'h0000, gpio_out_q};
      OffGpioIn:   mmio_rd = {16'h0000, sync2_q};
      OffCycle:    mmio_rd = cycle_q;
      OffTimerCmp: mmio_rd = cmp_q;
      OffStatus:   mmio_rd = {25'd0, count_q, tx_empty, tx_full, ovf_q, hit_q};
      default:     mmio_rd = '0;
    endcase
  end

  assign bus.mem_rd_data = is_mmio ? mmio_rd : ram[ram_idx];
  assign bus.tx_valid    = !tx_empty;
  assign bus.tx_data     = tx_empty ? 8'h00 : fifo_q[rptr_q];
  assign gpio_out        = gpio_out_q;
  assign irq             = hit_q;

endmodule

// File: tb/tb_rv32i_mmio_responder.sv
module tb_rv32i_mmio_responder;

  localparam int SelRd    = 0;
  localparam int SelIrq   = 1;
  localparam int SelGpio  = 2;
  localparam int SelValid = 3;
  localparam int SelTx    = 4;
  localparam int SelTxQ   = 5;

  localparam logic [31:0] AGpioOut = 32'h8000_0000;
  localparam logic [31:0] AGpioIn  = 32'h8000_0004;
  localparam logic [31:0] ACycle   = 32'h8000_0008;
  localparam logic [31:0] ACmp     = 32'h8000_000C;
  localparam logic [31:0] AStatus  = 32'h8000_0010;
  localparam logic [31:0] ATx      = 32'h8000_0014;

  typedef struct {
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        irq;

  rv32i_mmio_responder_if bus ();

  rv32i_mmio_responder #(
    .RAM_WORDS(256)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent cycle count matching what CYCLE should read in the current cycle
  int unsigned tb_cyc;
  always @(posedge clk) begin
    if (rst) tb_cyc <= 0;
    else     tb_cyc <= tb_cyc + 1;
  end

  exp_t       exp_q[$];
  logic [7:0] tx_q[$];
  logic       chk_en;
  int         checks;
  int         errors;

  // Monitor: compares requested observations and every accepted TX byte
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    logic [7:0]  b;
    if (chk_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor: check requested with no expected value queued");
      end else begin
        e = exp_q.pop_front();
        case (e.sel)
          SelRd:    act = bus.mem_rd_data;
          SelIrq:   act = {31'd0, irq};
          SelGpio:  act = {16'd0, gpio_out};
          SelValid: act = {31'd0, bus.tx_valid};
          SelTx:    act = {24'd0, bus.tx_data};
          SelTxQ:   act = tx_q.size();
          default:  act = 32'hxxxx_xxxx;
        endcase
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.val);
        end
      end
    end
    if (bus.tx_valid && bus.tx_ready) begin
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_pop: got unexpected byte %h expected none", bus.tx_data);
      end else begin
        b = tx_q.pop_front();
        if (bus.tx_data !== b) begin
          errors++;
          $display("FAIL tx_pop: got %h expected %h", bus.tx_data, b);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int sel, input logic [31:0] v, input string n);
    exp_q.push_back('{sel: sel, val: v, name: n});
    chk_en = 1'b1;
    step();
    chk_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] v, input string n);
    bus.mem_addr = a;
    chk(SelRd, v, n);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.mem_addr    = a;
    bus.mem_wr_data = d;
    bus.mem_wr_ena  = 1'b1;
    step();
    bus.mem_wr_ena  = 1'b0;
  endtask

  // Write while checking that the same-cycle read still shows the old value
  task automatic wr_chk(input logic [31:0] a, input logic [31:0] d, input logic [31:0] v,
                        input string n);
    bus.mem_addr    = a;
    bus.mem_wr_data = d;
    bus.mem_wr_ena  = 1'b1;
    chk(SelRd, v, n);
    bus.mem_wr_ena  = 1'b0;
  endtask

  task automatic wait_until(input int unsigned n);
    int g = 0;
    while (tb_cyc != n && g < 2000) begin
      step();
      g++;
    end
    if (tb_cyc != n) begin
      $display("FAIL wait_until: got cycle %0d expected %0d", tb_cyc, n);
      $fatal(1, "cycle wait expired");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks          = 0;
    errors          = 0;
    chk_en          = 1'b0;
    rst             = 1'b1;
    gpio_in         = 16'h0000;
    bus.mem_addr    = 32'h0;
    bus.mem_wr_data = 32'h0;
    bus.mem_wr_ena  = 1'b0;
    bus.tx_ready    = 1'b0;
    step();
    step();

    // Reset output values
    chk(SelGpio, 32'h0, "rst_gpio_out");
    chk(SelValid, 32'h0, "rst_tx_valid");
    chk(SelTx, 32'h0, "rst_tx_data");
    chk(SelIrq, 32'h0, "rst_irq");

    // Counter from reset release
    rst = 1'b0;
    rd(ACycle, 32'd0, "cycle_0");
    rd(ACycle, 32'd1, "cycle_1");
    step();
    step();
    step();
    rd(ACycle, 32'd5, "cycle_5");
    rd(ACmp, 32'hFFFF_FFFF, "timer_cmp_reset");
    rd(AStatus, 32'h0000_0008, "status_reset");

    // Timer compare and W1C
    wr(ACmp, 32'd20);
    wait_until(20);
    chk(SelIrq, 32'h0, "irq_at_match");
    chk(SelIrq, 32'h1, "irq_after_match");
    chk(SelIrq, 32'h1, "irq_sticky");
    wr(AStatus, 32'h1);
    chk(SelIrq, 32'h0, "irq_w1c");
    wr(ACmp, 32'd40);
    wait_until(40);
    wr(AStatus, 32'h1);
    chk(SelIrq, 32'h1, "irq_set_wins");
    rd(AStatus, 32'h0000_0009, "status_hit");
    wr(AStatus, 32'h1);
    chk(SelIrq, 32'h0, "irq_clear2");

    // FIFO fill and overflow
    for (int i = 0; i < 5; i++) wr(ATx, 32'h41 + i);
    rd(AStatus, 32'h0000_0046, "status_full_ovf");
    chk(SelTx, 32'h41, "tx_head_stable");
    chk(SelValid, 32'h1, "tx_valid_full");
    for (int i = 0; i < 4; i++) tx_q.push_back(8'h41 + 8'(i));
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk(SelValid, 32'h0, "tx_valid_drained");
    chk(SelTx, 32'h0, "tx_data_drained");
    wr(AStatus, 32'h2);
    rd(AStatus, 32'h0000_0008, "status_ovf_clear");

    // Simultaneous push and pop at full
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(ATx, 32'h61 + i);
    tx_q.push_back(8'h61);
    tx_q.push_back(8'h62);
    tx_q.push_back(8'h63);
    tx_q.push_back(8'h64);
    tx_q.push_back(8'h55);
    bus.tx_ready = 1'b1;
    wr(ATx, 32'h55);
    rd(AStatus, 32'h0000_0044, "status_push_pop_full");
    for (int i = 0; i < 4; i++) step();
    chk(SelValid, 32'h0, "tx_valid_after_pp");

    // GPIO and reserved offsets
    wr(AGpioOut, 32'h1234_ABCD);
    chk(SelGpio, 32'h0000_ABCD, "gpio_out_pin");
    rd(AGpioOut, 32'h0000_ABCD, "gpio_out_rb");
    gpio_in = 16'h5A5A;
    step();
    rd(AGpioIn, 32'h0, "gpio_in_1edge");
    rd(AGpioIn, 32'h0000_5A5A, "gpio_in_2edge");
    rd(32'h8000_0018, 32'h0, "rsvd18_rd");
    wr(32'h8000_0018, 32'hFFFF_FFFF);
    wr(32'h8000_001C, 32'hFFFF_FFFF);
    rd(32'h8000_0018, 32'h0, "rsvd18_after_wr");
    rd(32'h8000_001C, 32'h0, "rsvd1c_after_wr");
    rd(AGpioOut, 32'h0000_ABCD, "gpio_out_unchanged");
    rd(ATx, 32'h0, "tx_data_reads_0");

    // RAM
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_rd");
    rd(32'h0000_0410, 32'hDEAD_BEEF, "ram_alias");
    rd(32'h0000_0013, 32'hDEAD_BEEF, "ram_low_bits");
    wr_chk(32'h0000_0010, 32'hCAFE_F00D, 32'hDEAD_BEEF, "ram_same_cycle_old");
    rd(32'h0000_0010, 32'hCAFE_F00D, "ram_new");

    // Reset mid-operation: queued bytes dropped, RAM retained
    bus.tx_ready = 1'b0;
    wr(ATx, 32'h77);
    wr(ATx, 32'h78);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk(SelValid, 32'h0, "midrst_tx_valid");
    chk(SelTx, 32'h0, "midrst_tx_data");
    chk(SelGpio, 32'h0, "midrst_gpio_out");
    chk(SelIrq, 32'h0, "midrst_irq");
    rd(AStatus, 32'h0000_0008, "midrst_status");
    rd(32'h0000_0010, 32'hCAFE_F00D, "midrst_ram_kept");
    bus.tx_ready = 1'b1;
    step();
    step();
    chk(SelTxQ, 32'h0, "tx_queue_drained");
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_mmio_responder.md
# rv32i_mmio_responder

Memory-side responder for the multicycle RV32I core's single shared memory port (`mem_addr`, `mem_wr_data`, `mem_wr_ena`, `mem_rd_data`). It decodes each core access into a word-addressed RAM region or a small MMIO register bank. The register bank holds a GPIO output latch, a synchronized GPIO input, a free-running cycle counter with a compare timer, and a 4-entry byte TX FIFO with a valid/ready drain port. It sits between the core and the board pins/serializer and is the only memory the core sees.

## Interface
- `RAM_WORDS`, 256: RAM depth in 32-bit words; power of two, at least 4.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_addr`  in  32  byte address from core; bits [1:0] ignored (word access only).
- `mem_wr_data`  in  32  write data from core.
- `mem_wr_ena`  in  1  write strobe; write commits at the rising edge where it is high.
- `mem_rd_data`  out  32  read data for the current `mem_addr`; combinational.
- `gpio_in`  in  16  asynchronous board inputs.
- `gpio_out`  out  16  GPIO output latch.
- `tx_data`  out  8  FIFO head byte; 0 when FIFO is empty.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  consumer accepts the head byte this cycle.
- `irq`  out  1  equals the sticky STATUS.timer_hit bit.

## Operation
- Decode: `mem_addr[31]`=0 selects RAM; =1 selects MMIO at offset `mem_addr[4:2]`.
- RAM: index `mem_addr[log2(RAM_WORDS)+1:2]`; higher bits alias. Read is asynchronous. Write is synchronous, full word. RAM contents are not reset.
- MMIO map (byte offsets):
  - 0x00 GPIO_OUT: RW, bits[15:0]; upper bits read 0.
  - 0x04 GPIO_IN: RO; two-flop synchronized `gpio_in` in [15:0].
  - 0x08 CYCLE: RO; 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF→0.
  - 0x0C TIMER_CMP: RW, 32 bits.
  - 0x10 STATUS:
    - bit0 timer_hit: sticky, W1C.
    - bit1 tx_overflow: sticky, W1C.
    - bit2 tx_full (RO).
    - bit3 tx_empty (RO).
    - bits[6:4] tx_count 0..4 (RO).
    - Other bits read 0.
  - 0x14 TX_DATA: WO; a write pushes `mem_wr_data[7:0]`. Reads return 0.
  - Offsets 0x18, 0x1C: read 0; writes ignored.
- Writes to RO registers/bits are ignored.
- Timer: timer_hit sets on any cycle where CYCLE == TIMER_CMP (compare uses the pre-increment value). If set and W1C occur in the same cycle, set wins.
- TX FIFO: 4 entries, circular, 2-bit read/write pointers, 3-bit count.
  - Pop when `tx_valid && tx_ready`.
  - Push when a TX_DATA write occurs and (count<4 or a pop occurs this cycle).
  - A push while full with no pop is dropped and sets tx_overflow; FIFO contents are unchanged.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Order is strictly FIFO; `tx_data` is stable while `tx_valid && !tx_ready`.

## Timing
- Reset values: GPIO_OUT=0, CYCLE=0, TIMER_CMP=0xFFFF_FFFF, timer_hit=0, tx_overflow=0, FIFO empty (count 0, pointers 0), GPIO_IN synchronizer=0.
- Reset output values: `gpio_out`=0, `tx_valid`=0, `tx_data`=0, `irq`=0.
- Reset mid-operation empties the FIFO (queued bytes are lost) and clears all sticky bits. RAM is retained.
- Read latency: 0 cycles. `mem_rd_data` reflects state before the current edge. The core samples it at the next rising edge.
- Write-to-read visibility: next cycle. A read of the address being written in the same cycle returns the old value.
- CYCLE reads 0 in the first cycle after `rst` deasserts, and N in the N-th cycle after.
- `gpio_in` change appears in GPIO_IN after 2 rising edges.
- `irq` rises the cycle after the CYCLE==TIMER_CMP match.
- A FIFO push is visible on `tx_valid`/`tx_data` the cycle after the write edge.

## Test plan
- RAM: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 → 0xDEADBEEF. Read 0x0000_0410 with RAM_WORDS=256 → 0xDEADBEEF (alias). Read 0x0000_0013 → same word.
- Reset/counter: release `rst`, read CYCLE on cycles 0, 1, 5 → 0, 1, 5. Read TIMER_CMP → 0xFFFF_FFFF. STATUS → 0x0000_0008.
- Timer: write TIMER_CMP=20, then wait.
  - `irq`=1 from the cycle after CYCLE=20 and stays high.
  - Write STATUS=0x1 → `irq` clears.
  - Set and W1C in the same cycle → bit stays 1.
- FIFO fill/overflow: hold `tx_ready`=0 and push 0x41, 0x42, 0x43, 0x44, 0x45.
  - STATUS → full=1, count=4, overflow=1.
  - Raise `tx_ready` → `tx_data` sequence 0x41..0x44.
  - Then `tx_valid`=0 and `tx_data`=0.
- FIFO simultaneous: with count=4 and `tx_ready`=1, push 0x55 → count stays 4, no overflow, 0x55 emerges last.
- GPIO: write GPIO_OUT=0x1234ABCD → `gpio_out`=0xABCD, readback 0x0000ABCD. Drive `gpio_in`=0x5A5A → GPIO_IN reads 0x5A5A after 2 cycles. Access to 0x8000_0018 reads 0 and its writes change nothing.
